// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: opcode encoding shared by the pc sequencer and its return-address stack
package pc_seq_pkg;
  localparam int OPW = 3;
  typedef enum logic [OPW-1:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_JUMP   = 3'b010,
    OP_BRANCH = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101,
    OP_RSV6   = 3'b110,
    OP_RSV7   = 3'b111
  } op_e;
endpackage

// File: rtl/pc_ras_stack.sv
// pc_ras_stack: circular LIFO of return addresses; a push when full overwrites the oldest entry
module pc_ras_stack #(
  parameter int AW = 16,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic [CW-1:0] count
);
  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wp, wp_inc, wp_dec;
  logic full;
  assign full = count == CW'(DEPTH);
  assign wp_inc = (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
  assign wp_dec = (wp == '0) ? PW'(DEPTH - 1) : wp - 1'b1;
  assign dout = mem[wp_dec];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      count <= '0;
    end else if (push) begin
      wp <= wp_inc;
      count <= full ? count : count + 1'b1;
    end else if (pop && count != '0) begin
      wp <= wp_dec;
      count <= count - 1'b1;
    end
  end
  // storage is deliberately unreset: entries above count are never read
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with jump/branch/call/return; PC_SEQUENCER_IRQ_EN adds an interrupt entry
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int AW = 16,
  parameter int DEPTH = 8,
  parameter logic [AW-1:0] RESET_VEC = '0,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] op,
  input  logic [AW-1:0]  target,
  input  logic [AW-1:0]  offset,
  output logic [AW-1:0]  pc,
  output logic [CW-1:0]  ras_count,
  output logic           ras_full,
  output logic           ras_empty,
  output logic           err
`ifdef PC_SEQUENCER_IRQ_EN
  ,
  input  logic           irq_req,
  input  logic [AW-1:0]  irq_vec,
  output logic           irq_ack
`endif
);
  logic [AW-1:0] pc_n, push_val, ras_top;
  logic push, pop, err_n;
  assign ras_full = ras_count == CW'(DEPTH);
  assign ras_empty = ras_count == '0;
  pc_ras_stack #(.AW(AW), .DEPTH(DEPTH)) u_ras (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .din(push_val), .dout(ras_top), .count(ras_count)
  );
  always_comb begin
    push = 1'b0;
    pop = 1'b0;
    pc_n = pc;
    err_n = 1'b0;
    push_val = pc + 1'b1;
    case (op)
      OP_HOLD: pc_n = pc;
      OP_INC: pc_n = pc + 1'b1;
      OP_JUMP: pc_n = target;
      OP_BRANCH: pc_n = pc + offset;
      OP_CALL: begin
        push = 1'b1;
        pc_n = target;
        err_n = ras_full;
      end
      OP_RET: begin
        pop = !ras_empty;
        pc_n = ras_empty ? pc + 1'b1 : ras_top;
        err_n = ras_empty;
      end
      default: err_n = 1'b1;
    endcase
`ifdef PC_SEQUENCER_IRQ_EN
    // an interrupt returns to the interrupted instruction, not the next one
    if (irq_req) begin
      push = 1'b1;
      pop = 1'b0;
      push_val = pc;
      pc_n = irq_vec;
      err_n = ras_full;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VEC;
      err <= 1'b0;
    end else begin
      pc <= pc_n;
      err <= err_n;
    end
  end
`ifdef PC_SEQUENCER_IRQ_EN
  always_ff @(posedge clk) irq_ack <= !rst && irq_req;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench; build with PC_SEQUENCER_IRQ_EN to also exercise the interrupt path
module tb_pc_sequencer;
  import pc_seq_pkg::*;
  typedef struct {
    logic [15:0] pc;
    logic [3:0]  cnt;
    logic        err;
    logic        ack;
  } exp_t;
  logic clk = 0, rst = 1, irq_req = 0, err, ras_full, ras_empty, irq_ack;
  logic [2:0] op = OP_HOLD;
  logic [15:0] target = 0, offset = 0, irq_vec = 0, pc;
  logic [3:0] ras_count;
  exp_t q[$];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  pc_sequencer #(.AW(16), .DEPTH(8), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .rst(rst), .op(op), .target(target), .offset(offset),
    .pc(pc), .ras_count(ras_count), .ras_full(ras_full), .ras_empty(ras_empty), .err(err)
`ifdef PC_SEQUENCER_IRQ_EN
    , .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack)
`endif
  );
`ifndef PC_SEQUENCER_IRQ_EN
  assign irq_ack = 1'b0;
`endif
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", int'(pc), int'(e.pc));
      chk("ras_count", int'(ras_count), int'(e.cnt));
      chk("err", int'(err), int'(e.err));
      chk("ras_full", int'(ras_full), int'(e.cnt == 4'd8));
      chk("ras_empty", int'(ras_empty), int'(e.cnt == 4'd0));
      chk("irq_ack", int'(irq_ack), int'(e.ack));
    end
  end
  task automatic step(input logic r, input logic [2:0] o, input logic [15:0] t, input logic [15:0] f,
                      input logic [15:0] ep, input logic [3:0] ec, input logic ee,
                      input logic ir = 1'b0, input logic [15:0] iv = 16'h0, input logic ea = 1'b0);
    @(negedge clk);
    rst = r; op = o; target = t; offset = f; irq_req = ir; irq_vec = iv;
    q.push_back('{ep, ec, ee, ea});
  endtask
  initial begin
    step(1, OP_HOLD, 0, 0, 16'h0000, 0, 0);
    step(0, OP_JUMP, 16'hFFFF, 0, 16'hFFFF, 0, 0);
    step(0, OP_INC, 0, 0, 16'h0000, 0, 0);
    step(0, OP_JUMP, 16'h0010, 0, 16'h0010, 0, 0);
    step(0, OP_BRANCH, 0, 16'hFFF0, 16'h0000, 0, 0);
    step(0, OP_BRANCH, 0, 16'h0005, 16'h0005, 0, 0);
    step(0, OP_BRANCH, 0, 16'hFFFE, 16'h0003, 0, 0);
    step(0, OP_HOLD, 16'h1234, 0, 16'h0003, 0, 0);
    step(0, OP_RSV6, 16'h1234, 0, 16'h0003, 0, 1);
    step(0, OP_HOLD, 0, 0, 16'h0003, 0, 0);
    step(0, OP_RSV7, 0, 0, 16'h0003, 0, 1);
    step(0, OP_JUMP, 16'h0100, 0, 16'h0100, 0, 0);
    step(0, OP_CALL, 16'h0200, 0, 16'h0200, 1, 0);
    step(0, OP_CALL, 16'h0300, 0, 16'h0300, 2, 0);
    step(0, OP_RET, 0, 0, 16'h0201, 1, 0);
    step(0, OP_RET, 0, 0, 16'h0101, 0, 0);
    // overflow: call k jumps to k*0x10 and pushes (k-1)*0x10+1
    step(0, OP_JUMP, 16'h0000, 0, 16'h0000, 0, 0);
    for (int k = 1; k <= 9; k++)
      step(0, OP_CALL, 16'(k * 16), 0, 16'(k * 16), 4'(k > 8 ? 8 : k), k == 9);
    for (int k = 8; k >= 1; k--)
      step(0, OP_RET, 0, 0, 16'(k * 16 + 1), 4'(k - 1), 0);
    step(0, OP_RET, 0, 0, 16'h0012, 0, 1);
    step(0, OP_HOLD, 0, 0, 16'h0012, 0, 0);
    step(0, OP_CALL, 16'h0010, 0, 16'h0010, 1, 0);
    step(0, OP_CALL, 16'h0020, 0, 16'h0020, 2, 0);
    step(0, OP_CALL, 16'h0030, 0, 16'h0030, 3, 0);
    step(1, OP_CALL, 16'h0040, 0, 16'h0000, 0, 0);
    step(0, OP_RET, 0, 0, 16'h0001, 0, 1);
`ifdef PC_SEQUENCER_IRQ_EN
    step(0, OP_JUMP, 16'h0040, 0, 16'h0040, 0, 0);
    step(0, OP_CALL, 16'h0123, 0, 16'h0800, 1, 0, 1'b1, 16'h0800, 1'b1);
    step(0, OP_HOLD, 0, 0, 16'h0800, 1, 0);
    step(0, OP_RET, 0, 0, 16'h0040, 0, 0);
`endif
    step(0, OP_HOLD, 0, 0, 16'h0040 * 0 + (`ifdef PC_SEQUENCER_IRQ_EN 16'h0040 `else 16'h0001 `endif), 0, 0);
    @(negedge clk);
    op = OP_HOLD;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
